// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch front end.
// Mirrors the openmips defines that the fetch path relies on, plus the
// default prefetch queue depth.
package if_prefetch_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Widths of the instruction address and instruction buses.
  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;

  // Default number of prefetch queue entries (power of two, >= 2).
  localparam int unsigned IfQueueDepth = 4;

endpackage

// File: rtl/if_fetch_fifo.sv
// Prefetch queue: Depth x Width synchronous FIFO with push, pop and flush.
// The occupancy count is kept explicitly; full/empty are derived from it by the
// user, not from pointer comparison. The head entry is always driven on rdata_o.
//
// Ports:
//   clk      in  clock, rising edge
//   rst      in  synchronous active-high reset (empties the queue)
//   push_i   in  write wdata_i at the write pointer
//   pop_i    in  advance the read pointer (caller guarantees non-empty)
//   flush_i  in  empty the queue; overrides push/pop
//   wdata_i  in  entry to write
//   rdata_o  out entry at the read pointer
//   level_o  out current occupancy, 0..Depth
module if_fetch_fifo
  import if_prefetch_pkg::*;
#(
  parameter int unsigned Depth = IfQueueDepth,
  parameter int unsigned Width = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] level_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = $clog2(Depth+1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             wr_en;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    wr_en   = 1'b0;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      // Pointers are log2(Depth) bits, so Depth being a power of two makes
      // the increment wrap on its own.
      if (push_i) begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + PtrW'(1);
      end
      if (pop_i) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage has no reset; an entry is only observed after it has been written.
  always_ff @(posedge clk) begin
    if (wr_en && (rst != RstEnable)) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: sequential PC, combinational ROM access and a
// prefetch queue feeding decode with a valid/stall handshake. A branch
// redirect flushes the queue and restarts fetch at the target.
//
// Ports:
//   clk              in  clock, rising edge
//   rst              in  synchronous active-high reset
//   rom_data_i       in  ROM instruction for rom_addr_o (same cycle)
//   rom_addr_o       out fetch address (internal PC)
//   rom_ce_o         out ROM enable; high only when a fetch enters the queue
//   stall_i          in  decode cannot take the head this cycle
//   branch_flag_i    in  redirect request (highest priority)
//   branch_target_i  in  redirect address, used unmodified
//   id_pc_o          out PC of queue head (0 when empty)
//   id_inst_o        out instruction at queue head (0 when empty)
//   id_valid_o       out queue head valid
//   level_o          out queue occupancy
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = InstAddrBus,
  parameter int unsigned       INST_W   = InstBus,
  parameter int unsigned       DEPTH    = IfQueueDepth,
  parameter int unsigned       PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INST_W-1:0]          rom_data_i,
  output logic [ADDR_W-1:0]          rom_addr_o,
  output logic                       rom_ce_o,
  input  logic                       stall_i,
  input  logic                       branch_flag_i,
  input  logic [ADDR_W-1:0]          branch_target_i,
  output logic [ADDR_W-1:0]          id_pc_o,
  output logic [INST_W-1:0]          id_inst_o,
  output logic                       id_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned LvlW   = $clog2(DEPTH+1);
  localparam int unsigned EntryW = ADDR_W + INST_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              run_q;
  logic              rst_on;
  logic              push, pop, flush;
  logic [LvlW-1:0]   fifo_level;
  logic [EntryW-1:0] head;

  if_fetch_fifo #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({pc_q, rom_data_i}),
    .rdata_o (head),
    .level_o (fifo_level)
  );

  always_comb begin
    rst_on     = (rst == RstEnable);
    // Outputs read as reset values for the whole time rst is high, including
    // the cycle it is raised mid-operation.
    id_valid_o = !rst_on && (fifo_level != '0);
    pop        = id_valid_o && !stall_i && !branch_flag_i;
    // A full queue only takes a new entry when the head leaves in the same cycle.
    push       = !rst_on && run_q && !branch_flag_i &&
                 ((fifo_level < LvlW'(DEPTH)) || (id_valid_o && !stall_i));
    flush      = branch_flag_i;

    pc_d = pc_q;
    if (branch_flag_i) begin
      pc_d = branch_target_i;
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end

    rom_ce_o   = push ? ChipEnable : ChipDisable;
    rom_addr_o = rst_on ? RESET_PC : pc_q;
    level_o    = rst_on ? '0 : fifo_level;
    id_pc_o    = id_valid_o ? head[EntryW-1:INST_W] : '0;
    id_inst_o  = id_valid_o ? head[INST_W-1:0] : '0;
  end

  // run_q delays the first fetch to the cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_q  <= RESET_PC;
      run_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      run_q <= 1'b1;
    end
  end

endmodule
